display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_pkg.sv | 20 ++
 rtl/display_scan_seg7_decode.sv | 26 ++
 rtl/display_scan.sv | 104 ++++++++++
 tb/tb_display_scan.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low segment
// patterns (bit 0 = a .. bit 6 = g) and the adjust-select "no slot" threshold.
package display_scan_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // adj_sel values at or above this select no digit slot
   localparam logic [2:0] SEL_NONE  = 3'd4;

endpackage

// File: rtl/display_scan_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank.
module seg7_decode
   import display_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner with anode dead time and a blinking
// adjust-mode cursor. Outputs are registered, one cycle behind the inputs.
module display_scan
   import display_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int DEAD_CYC  = 2000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic        adj,
   input  logic [2:0]  adj_sel,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD  = CW'(DEAD_CYC);
   localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;
   logic          adj_q;
   logic [2:0]    sel_q;
   logic          restart;
   logic [3:0]    cur_bcd;
   logic [6:0]    dec_seg;
   logic [6:0]    seg_next;
   logic [3:0]    an_next;
   logic          dead;
   logic          cursor_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Entering adjust or moving the cursor restarts the blink lit, so the
   // operator sees the selected digit right away.
   assign restart = adj && (!adj_q || (adj_sel != sel_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         adj_q     <= 1'b0;
         sel_q     <= '0;
      end else begin
         adj_q <= adj;
         sel_q <= adj_sel;
         if (restart) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (blink_cnt == BLNK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign cur_bcd = digits[{idx, 2'b00} +: 4];

   seg7_decode u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

   always_comb begin
      dead       = (cnt < CNT_DEAD);
      cursor_off = adj && (adj_sel < SEL_NONE) && (adj_sel[1:0] == idx) && !blink_on;
      an_next    = 4'hF;
      seg_next   = SEG_BLANK;
      if (!dead) begin
         an_next  = ~(4'b0001 << idx);
         seg_next = cursor_off ? SEG_BLANK : dec_seg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= 4'hF;
      end else begin
         seg <= seg_next;
         an  <= an_next;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: fixed vector tables, hand-built corner
// sequences and randomized traffic against a time-based reference model.
module tb_display_scan;

   localparam int SCAN  = 4;
   localparam int DEAD  = 1;
   localparam int BLINK = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits = '0;
   logic        adj = 1'b0;
   logic [2:0]  adj_sel = '0;
   logic [6:0]  seg;
   logic [3:0]  an;

   int errors = 0;
   int checks = 0;

   // model state: k = clock edges since reset release, r = edge of last blink restart
   int          k = 0;
   int          r = 0;
   logic        prev_adj = 1'b0;
   logic [2:0]  prev_sel = '0;
   logic [10:0] last_exp;

   logic [6:0] seg_tab [16];

   typedef struct {
      logic        do_rst;
      logic [15:0] dig;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
   } vec_t;

   vec_t vecs [32];

   display_scan #(.SCAN_DIV(SCAN), .DEAD_CYC(DEAD), .BLINK_DIV(BLINK)) dut (
      .clk     (clk),
      .rst     (rst),
      .digits  (digits),
      .adj     (adj),
      .adj_sel (adj_sel),
      .seg     (seg),
      .an      (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
      end
   endtask

   // Expected {an, seg} registered from the scan position at edge count st.
   function automatic logic [10:0] model(int st, logic [15:0] dg, logic ad, logic [2:0] sl);
      int          slot_pos;
      int          slot;
      int          d;
      logic [6:0]  s;
      logic        lit;
      logic [3:0]  a;
      slot_pos = st % SCAN;
      slot     = (st / SCAN) % 4;
      if (slot_pos < DEAD) return {4'hF, 7'h7F};
      d   = (dg >> (4 * slot)) & 16'hF;
      s   = seg_tab[d];
      lit = (((st - r) / BLINK) % 2) == 0;
      if (ad && sl < 4 && int'(sl) == slot && !lit) s = 7'h7F;
      a = 4'hF;
      a[slot] = 1'b0;
      return {a, s};
   endfunction

   task automatic step();
      logic restart;
      restart  = adj && (!prev_adj || adj_sel != prev_sel);
      last_exp = model(k, digits, adj, adj_sel);
      @(posedge clk);
      k++;
      if (restart) r = k;
      prev_adj = adj;
      prev_sel = adj_sel;
      @(negedge clk);
   endtask

   task automatic step_check(input string name);
      step();
      check({name, "_an"}, {3'b0, an}, {3'b0, last_exp[10:7]});
      check({name, "_seg"}, seg, last_exp[6:0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_an", {3'b0, an}, 7'h0F);
      check("rst_seg", seg, 7'h7F);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      r = 0;
      prev_adj = 1'b0;
      prev_sel = '0;
   endtask

   initial begin
      logic [3:0] an_seq [16];
      logic [6:0] s1234 [4];
      logic [6:0] sfa90 [4];
      int         n;
      int         sawb;
      int         blanks;

      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      an_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
      s1234 = '{7'h19, 7'h30, 7'h24, 7'h79};
      sfa90 = '{7'h40, 7'h10, 7'h7F, 7'h7F};
      for (int i = 0; i < 16; i++) begin
         vecs[i]      = '{(i == 0), 16'h1234, an_seq[i], (i % 4 == 0) ? 7'h7F : s1234[i / 4]};
         vecs[i + 16] = '{(i == 0), 16'hFA90, an_seq[i], (i % 4 == 0) ? 7'h7F : sfa90[i / 4]};
      end

      // scan order and invalid BCD tables
      for (int i = 0; i < 32; i++) begin
         if (vecs[i].do_rst) begin
            digits = vecs[i].dig;
            do_reset();
         end
         digits = vecs[i].dig;
         step();
         check("tab_an", {3'b0, an}, {3'b0, vecs[i].exp_an});
         check("tab_seg", seg, vecs[i].exp_seg);
      end

      // blink on slot 2; adj already high at release restarts the blink
      digits  = 16'h8888;
      adj     = 1'b1;
      adj_sel = 3'd2;
      do_reset();
      blanks = 0;
      for (int i = 0; i < 64; i++) begin
         step_check("blink");
         if (an != 4'hF && seg == 7'h7F) begin
            blanks++;
            check("blink_slot", {3'b0, an}, 7'h0B);
         end
      end
      check("blink_seen", (blanks > 0) ? 7'd1 : 7'd0, 7'd1);

      // move cursor during the blank phase: slot 1 must be lit 8 cycles from the change
      n = 0;
      while ((((k - r) / BLINK) % 2) == 0 && n < 40) begin
         step_check("pre_move");
         n++;
      end
      check("reach_blank_phase", (n < 40) ? 7'd1 : 7'd0, 7'd1);
      adj_sel = 3'd1;
      step_check("move");
      for (int i = 0; i < BLINK; i++) begin
         step_check("after_move");
         if (an != 4'hF) check("after_move_lit", seg, 7'h00);
      end
      for (int i = 0; i < 24; i++) step_check("after_move_run");

      // void select never blanks a digit
      adj_sel = 3'd5;
      for (int i = 0; i < 64; i++) begin
         step_check("void");
         if (an != 4'hF) check("void_lit", seg, 7'h00);
      end

      // asynchronous reset in the middle of slot 2
      adj = 1'b0;
      digits = 16'h1234;
      do_reset();
      sawb = 0;
      for (int i = 0; i < 20 && sawb == 0; i++) begin
         step_check("seek_b");
         if (an == 4'hB && (k % SCAN) == 2) sawb = 1;
      end
      check("found_b", sawb[6:0], 7'd1);
      rst = 1'b1;
      #1;
      check("async_an", {3'b0, an}, 7'h0F);
      check("async_seg", seg, 7'h7F);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      r = 0;
      prev_adj = 1'b0;
      prev_sel = '0;
      step();
      check("post_rst_dead", {3'b0, an}, 7'h0F);
      step();
      check("post_rst_first", {3'b0, an}, 7'h0E);
      check("post_rst_seg", seg, 7'h19);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 19) == 0) adj = ~adj;
         if ($urandom_range(0, 29) == 0) adj_sel = 3'($urandom_range(0, 7));
         step_check("rand");
         check("one_hot", ($countones(~an) <= 1) ? 7'd1 : 7'd0, 7'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
